// File: rtl/Minivan_pkg.sv
// Shared register-bank definitions for the Minivan lighting subsystem.
// Holds the configuration wire bundle and the RGB PWM period constant.
package Minivan_pkg;

  localparam int DUTY_W     = 8;
  localparam int PWM_PERIOD = 255;

  typedef struct packed {
    logic              enable_stuf;
    logic [DUTY_W-1:0] pwm_duty_red;
    logic [DUTY_W-1:0] pwm_duty_green;
    logic [DUTY_W-1:0] pwm_duty_blue;
  } rb_sys_cfg_wire_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Bundle of the RGB driver's configuration input and drive/status outputs.
// The master side supplies configuration; the slave side is the driver.
interface rgb_pwm_driver_if;
  import Minivan_pkg::*;

  rb_sys_cfg_wire_t cfg;
  logic             pwm_red;
  logic             pwm_green;
  logic             pwm_blue;
  logic             period_start;
  logic             running;

  modport master (
    output cfg,
    input  pwm_red, pwm_green, pwm_blue, period_start, running
  );

  modport slave (
    input  cfg,
    output pwm_red, pwm_green, pwm_blue, period_start, running
  );

endinterface

// File: rtl/pwm_channel.sv
// One PWM colour channel: a shadow duty register reloaded on a strobe, and a
// registered compare of the next counter value against the next shadow.
module pwm_channel #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] cnt_next,
  input  logic             run_next,
  output logic             pwm
);

  logic [CNT_W-1:0] shadow_d, shadow_q;
  logic             pwm_d, pwm_q;

  // Compare against next-cycle values so the output lines up with the counter.
  always_comb begin
    shadow_d = load ? duty : shadow_q;
    pwm_d    = run_next && (cnt_next < shadow_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB PWM driver: prescaler, period counter and IDLE/RUN control,
// feeding three glitch-free shadowed compare channels.
module rgb_pwm_driver
  import Minivan_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  rb_sys_cfg_wire_t cfg,
  output logic             pwm_red,
  output logic             pwm_green,
  output logic             pwm_blue,
  output logic             period_start,
  output logic             running
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** CNT_W) - 2);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_d, state_q;
  logic [PRE_W-1:0] pre_d, pre_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             period_start_d, period_start_q;
  logic             running_d, running_q;
  logic             en, tick, wrap, load;

  // Dropping enable always wins over a wrap, so no load occurs on that cycle.
  always_comb begin
    en        = cfg.enable_stuf;
    tick      = (pre_q == PRE_LAST);
    wrap      = tick && (cnt_q == CNT_LAST);
    state_d   = en ? RUN : IDLE;
    running_d = en;
    pre_d     = '0;
    cnt_d     = '0;
    load      = 1'b0;
    if (state_q == RUN && en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      cnt_d = tick ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
      load  = wrap;
    end else if (state_q == IDLE && en) begin
      load = 1'b1;
    end
    period_start_d = load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pre_q          <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      running_q      <= running_d;
    end
  end

  assign period_start = period_start_q;
  assign running      = running_q;

  pwm_channel #(.CNT_W(CNT_W)) u_red (
    .clk(clk), .rst(rst), .load(load), .duty(CNT_W'(cfg.pwm_duty_red)),
    .cnt_next(cnt_d), .run_next(running_d), .pwm(pwm_red)
  );

  pwm_channel #(.CNT_W(CNT_W)) u_green (
    .clk(clk), .rst(rst), .load(load), .duty(CNT_W'(cfg.pwm_duty_green)),
    .cnt_next(cnt_d), .run_next(running_d), .pwm(pwm_green)
  );

  pwm_channel #(.CNT_W(CNT_W)) u_blue (
    .clk(clk), .rst(rst), .load(load), .duty(CNT_W'(cfg.pwm_duty_blue)),
    .cnt_next(cnt_d), .run_next(running_d), .pwm(pwm_blue)
  );

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 Parameter PRESCALE, default 1, meaning input clocks per PWM tick (1..256).
REQ-002 Parameter CNT_W, default 8, meaning PWM counter and duty width.
REQ-003 Port clk, input, 1, the single block clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port cfg, input, rb_sys_cfg_wire_t, register-bank configuration; uses enable_stuf, pwm_duty_red, pwm_duty_green and pwm_duty_blue only.
REQ-006 Port pwm_red, output, 1, red PWM drive, registered.
REQ-007 Port pwm_green, output, 1, green PWM drive, registered.
REQ-008 Port pwm_blue, output, 1, blue PWM drive, registered.
REQ-009 Port period_start, output, 1, one-clock pulse on the cycle that shadow duties load.
REQ-010 Port running, output, 1, high while in state RUN.

Function
REQ-011 The block SHALL implement two states, IDLE and RUN; IDLE->RUN when cfg.enable_stuf=1, RUN->IDLE when cfg.enable_stuf=0, both evaluated every clock.
REQ-012 The prescaler SHALL count 0..PRESCALE-1 in RUN and produce tick on its terminal count, then wrap to 0; PRESCALE=1 means tick every clock.
REQ-013 The PWM counter SHALL advance on tick only, counting 0..2^CNT_W-2 (0..254), then wrapping to 0, giving a 255-tick period.
REQ-014 Shadow duties SHALL load from the cfg duty fields on the IDLE->RUN transition and on every tick where the counter wraps to 0; period_start SHALL pulse on exactly those cycles.
REQ-015 Cfg duty changes SHALL NOT affect the outputs until the next shadow load, so no glitches occur mid-period.
REQ-016 Each pwm_x SHALL be registered, with pwm_x <= running_next && (cnt_next < shadow_x_next); the output is high for duty ticks per period.
REQ-017 Duty 0 SHALL give constant low, and duty 255 SHALL give constant high in RUN with no one-tick dropout at wrap.
REQ-018 On the IDLE->RUN transition, the prescaler and counter SHALL start at 0 and the outputs SHALL reflect the new shadow on the following clock.
REQ-019 On the RUN->IDLE transition, the outputs SHALL go low on the next clock, the counter and prescaler SHALL clear, and the shadows SHALL hold.
REQ-020 If enable_stuf drops on the same cycle as a wrap, IDLE SHALL win: no period_start pulse and no shadow load.

Reset
REQ-021 With rst=1 on a clock edge, the state SHALL be IDLE, the counter, prescaler and shadows SHALL be 0, and pwm_red, pwm_green, pwm_blue, period_start and running SHALL all be 0.
REQ-022 Reset asserted mid-period SHALL override every other input, and after release the block SHALL restart per REQ-018 if enable_stuf=1.

Structure
REQ-023 The constant PWM_PERIOD (255) SHALL live in Minivan_pkg beside rb_sys_cfg_wire_t; no new typedefs are needed.
REQ-024 One sub-module, pwm_channel, SHALL be instantiated three times; each instance holds a shadow register and a registered compare output, with a load strobe and counter as inputs.
REQ-025 The prescaler, counter and state machine SHALL live in the top level only.

Verification
REQ-026 Scenario: PRESCALE=1, red duty=128, enable -> pwm_red high for 128 clocks and low for 127 clocks, with period_start every 255 clocks.
REQ-027 Scenario: change green duty from 64 to 200 at counter 10 -> the current period keeps 64 high ticks and the next period shows 200.
REQ-028 Scenario: blue duty=0 and red duty=255 over 3 periods -> pwm_blue is constantly 0 and pwm_red is constantly 1 after the first output cycle.
REQ-029 Scenario: drop enable_stuf at counter 100 -> all outputs 0 and running 0 on the next clock; on re-enable, counting restarts at 0 with period_start asserted.
REQ-030 Scenario: PRESCALE=4, duty=10 -> high for 40 clocks of a 1020-clock period.
REQ-031 Scenario: assert rst for 1 clock mid-period with enable held -> outputs 0 during reset, then a fresh period starts per REQ-018.
